// File: rtl/systolic_result_drain.sv
// Result drain for the N x N systolic multiplier. It snapshots the finished matrix
// and streams it out in row-major order over valid/ready, so the array can start its next product.
module systolic_result_drain #(
  parameter int N  = 4,
  parameter int W  = 11,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N-1:0][N-1:0][W-1:0]   res_mat_i,
  input  logic                         done_i,
  input  logic                         clr_i,
  output logic [W-1:0]                 data_o,
  output logic [IW-1:0]                row_o,
  output logic [IW-1:0]                col_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         last_o,
  output logic                         busy_o,
  output logic                         overrun_o,
  output logic [7:0]                   frame_cnt_o
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                       state_reg, state_next;
  logic [N-1:0][N-1:0][W-1:0]   shadow_reg;
  logic [IW-1:0]                row_reg, col_reg;
  logic [IW-1:0]                row_step, col_step;
  logic [W-1:0]                 data_reg;
  logic                         overrun_reg;
  logic [7:0]                   frame_cnt_reg;
  logic                         at_last, xfer, capture, drop;

  assign valid_o     = (state_reg == DRAIN);
  assign busy_o      = (state_reg == DRAIN);
  assign at_last     = (row_reg == IW'(N-1)) && (col_reg == IW'(N-1));
  assign last_o      = valid_o && at_last;
  assign xfer        = valid_o && ready_i;
  assign data_o      = data_reg;
  assign row_o       = row_reg;
  assign col_o       = col_reg;
  assign overrun_o   = overrun_reg;
  assign frame_cnt_o = frame_cnt_reg;

  always_comb begin
    col_step = col_reg + 1'b1;
    row_step = row_reg;
    if (col_reg == IW'(N-1)) begin
      col_step = '0;
      row_step = row_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // A new matrix is only accepted when idle or exactly on the final transfer.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (done_i) begin
          capture    = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && at_last) begin
          if (done_i) capture    = 1'b1;
          else        state_next = IDLE;
        end else if (done_i) begin
          drop = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (capture) shadow_reg <= res_mat_i;
  end

  // Element (0,0) comes straight from the input since the shadow is loading in the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_reg       <= '0;
      col_reg       <= '0;
      data_reg      <= '0;
      overrun_reg   <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      if (capture) begin
        row_reg  <= '0;
        col_reg  <= '0;
        data_reg <= res_mat_i[0][0];
      end else if (xfer && !at_last) begin
        row_reg  <= row_step;
        col_reg  <= col_step;
        data_reg <= shadow_reg[row_step][col_step];
      end
      if (xfer && at_last) frame_cnt_reg <= frame_cnt_reg + 8'd1;
      if (drop)       overrun_reg <= 1'b1;
      else if (clr_i) overrun_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: each accepted matrix pushes its 16 expected
// beats, and a negedge monitor checks the head of the queue whenever valid_o is high.
module tb_systolic_result_drain;
  localparam int N  = 4;
  localparam int W  = 11;
  localparam int IW = 2;

  logic                       clk_i = 1'b0;
  logic                       rst_i = 1'b1;
  logic [N-1:0][N-1:0][W-1:0] res_mat_i = '0;
  logic                       done_i = 1'b0;
  logic                       clr_i = 1'b0;
  logic                       ready_i = 1'b1;
  logic [W-1:0]               data_o;
  logic [IW-1:0]              row_o, col_o;
  logic                       valid_o, last_o, busy_o, overrun_o;
  logic [7:0]                 frame_cnt_o;

  typedef struct {
    int d;
    int r;
    int c;
    int l;
  } beat_t;

  beat_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int xfer_count = 0;
  int ready_mode = 0;
  int rcnt = 0;
  int exp_frames = 0;

  systolic_result_drain #(.N(N), .W(W), .IW(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .res_mat_i(res_mat_i), .done_i(done_i), .clr_i(clr_i),
    .data_o(data_o), .row_o(row_o), .col_o(col_o), .valid_o(valid_o), .ready_i(ready_i),
    .last_o(last_o), .busy_o(busy_o), .overrun_o(overrun_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic align();
    @(posedge clk_i);
    #2;
  endtask

  // Mode 0 holds ready high; mode 1 gives the 1,0,0 repeating pattern.
  always @(posedge clk_i) begin
    #2;
    ready_i = (ready_mode == 0) ? 1'b1 : (rcnt % 3 == 0);
    rcnt++;
  end

  always @(negedge clk_i) begin
    beat_t b;
    if (!rst_i && valid_o) begin
      if (sb.size() == 0) begin
        check("spurious_beat", 32'(valid_o), 32'd0);
      end else begin
        check("data", 32'(data_o), sb[0].d);
        check("row",  32'(row_o),  sb[0].r);
        check("col",  32'(col_o),  sb[0].c);
        check("last", 32'(last_o), sb[0].l);
        if (ready_i) begin
          b = sb.pop_front();
          xfer_count++;
        end
      end
    end else if (!rst_i) begin
      check("last_idle", 32'(last_o), 32'd0);
    end
  end

  // Called at posedge+2; drives a one-cycle done_i and returns at the following posedge+2.
  task automatic pulse(input int base, input int step, input bit accept,
                       input bit from_idle, input bit with_clr);
    int v;
    if (from_idle) check("idle_before", 32'(valid_o), 32'd0);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        v = (base + step * (i * N + j)) & 2047;
        res_mat_i[i][j] = v[W-1:0];
        if (accept) sb.push_back('{v, i, j, int'(i == N-1 && j == N-1)});
      end
    end
    done_i = 1'b1;
    clr_i  = with_clr;
    align();
    done_i = 1'b0;
    clr_i  = 1'b0;
    if (from_idle) begin
      check("valid_rise", 32'(valid_o), 32'd1);
      check("first_data", 32'(data_o), base & 2047);
      check("first_row",  32'(row_o), 32'd0);
      check("first_col",  32'(col_o), 32'd0);
    end
  endtask

  task automatic wait_k(input int k);
    for (int n = 0; n < 200; n++) begin
      if (valid_o && (int'(row_o) * N + int'(col_o) == k)) return;
      align();
    end
    check("wait_k_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400; n++) begin
      align();
      if (!valid_o && sb.size() == 0) return;
    end
    check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    check("rst_data",    32'(data_o), 32'd0);
    check("rst_row",     32'(row_o), 32'd0);
    check("rst_col",     32'(col_o), 32'd0);
    check("rst_valid",   32'(valid_o), 32'd0);
    check("rst_last",    32'(last_o), 32'd0);
    check("rst_busy",    32'(busy_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_frames",  32'(frame_cnt_o), 32'd0);

    // Basic frame, ready held high
    align();
    pulse(100, 1, 1'b1, 1'b1, 1'b0);
    check("busy_drain", 32'(busy_o), 32'd1);
    wait_idle();
    exp_frames++;
    check("frames_basic", 32'(frame_cnt_o), exp_frames);
    check("busy_idle", 32'(busy_o), 32'd0);

    // Backpressure
    ready_mode = 1;
    xfer_count = 0;
    align();
    pulse(100, 1, 1'b1, 1'b1, 1'b0);
    wait_idle();
    exp_frames++;
    check("bp_xfers", 32'(xfer_count), 32'd16);
    check("frames_bp", 32'(frame_cnt_o), exp_frames);
    ready_mode = 0;

    // Back-to-back frames with done_i on the final transfer
    align();
    pulse(100, 1, 1'b1, 1'b1, 1'b0);
    wait_k(15);
    pulse(200, 1, 1'b1, 1'b0, 1'b0);
    check("b2b_valid", 32'(valid_o), 32'd1);
    check("b2b_data",  32'(data_o), 32'd200);
    check("b2b_row",   32'(row_o), 32'd0);
    check("b2b_col",   32'(col_o), 32'd0);
    check("b2b_frames_mid", 32'(frame_cnt_o), exp_frames + 1);
    wait_idle();
    exp_frames += 2;
    check("frames_b2b", 32'(frame_cnt_o), exp_frames);

    // Overrun: dropped pulse at beat 5
    align();
    pulse(100, 1, 1'b1, 1'b1, 1'b0);
    wait_k(5);
    pulse(300, 1, 1'b0, 1'b0, 1'b0);
    check("overrun_set", 32'(overrun_o), 32'd1);
    wait_idle();
    exp_frames++;
    check("overrun_sticky", 32'(overrun_o), 32'd1);
    check("frames_ovr", 32'(frame_cnt_o), exp_frames);
    clr_i = 1'b1;
    align();
    clr_i = 1'b0;
    check("overrun_clr", 32'(overrun_o), 32'd0);

    // Clear and drop in the same cycle: set wins
    align();
    pulse(100, 1, 1'b1, 1'b1, 1'b0);
    wait_k(3);
    pulse(300, 1, 1'b0, 1'b0, 1'b1);
    check("overrun_set_wins", 32'(overrun_o), 32'd1);
    wait_idle();
    exp_frames++;
    clr_i = 1'b1;
    align();
    clr_i = 1'b0;
    check("overrun_clr2", 32'(overrun_o), 32'd0);

    // Reset in the middle of a frame
    align();
    pulse(100, 1, 1'b1, 1'b1, 1'b0);
    wait_k(7);
    rst_i = 1'b1;
    #1;
    check("mid_rst_valid",  32'(valid_o), 32'd0);
    check("mid_rst_busy",   32'(busy_o), 32'd0);
    check("mid_rst_last",   32'(last_o), 32'd0);
    check("mid_rst_row",    32'(row_o), 32'd0);
    check("mid_rst_col",    32'(col_o), 32'd0);
    check("mid_rst_frames", 32'(frame_cnt_o), 32'd0);
    sb.delete();
    exp_frames = 0;
    repeat (2) align();
    rst_i = 1'b0;
    align();
    pulse(400, 1, 1'b1, 1'b1, 1'b0);
    wait_idle();
    exp_frames = 1;
    check("frames_after_rst", 32'(frame_cnt_o), exp_frames);

    // 256 frames with descending values from 2047: counter wraps 255 -> 0
    for (int f = 0; f < 256; f++) begin
      align();
      pulse(2047 - f, -1, 1'b1, 1'b1, 1'b0);
      wait_idle();
      exp_frames = (exp_frames + 1) % 256;
      check("frames_wrap", 32'(frame_cnt_o), exp_frames);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
